// File: rtl/sa_row_feeder.sv
// sa_row_feeder: pops rows from the async FIFO read port, skews lanes
// diagonally for the 3x3 systolic array and drains it with zero rows.
module sa_row_feeder #(
  parameter int LANES = 3,
  parameter int DW    = 8,
  parameter int ROWS  = 3,
  parameter int DRAIN = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [LANES*DW-1:0] fifo_rdata,
  input  logic                fifo_empty,
  output logic                fifo_rinc,
  output logic                sa_en,
  output logic [LANES*DW-1:0] sa_in,
  output logic                busy,
  output logic                done
);

  localparam int RW  = $clog2(ROWS + 1);
  localparam int DCW = $clog2(DRAIN + 1);
  localparam logic [RW-1:0]  ROWS_C = RW'(ROWS);
  localparam logic [RW-1:0]  ROWS_M1 = RW'(ROWS - 1);
  localparam logic [DCW-1:0] DRN_M1 = DCW'(DRAIN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [RW-1:0]       row_cnt;
  logic [DCW-1:0]      drn_cnt;
  logic                adv;
  logic [LANES*DW-1:0] inject;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:   if (start) state_nx = S_STREAM;
      S_STREAM: if (fifo_rinc && row_cnt == ROWS_M1) state_nx = S_DRN;
      S_DRN:    if (drn_cnt == DRN_M1) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // The array only steps when a row is injected, so stalls freeze the skew.
  always_comb begin
    fifo_rinc = 1'b0;
    adv       = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    inject    = '0;
    unique case (state)
      S_IDLE:   busy = 1'b0;
      S_STREAM: begin
        fifo_rinc = !fifo_empty && (row_cnt < ROWS_C) && !rst;
        adv       = fifo_rinc;
        inject    = fifo_rdata;
      end
      S_DRN:    adv  = !rst;
      S_DONE:   done = 1'b1;
      default:  busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt <= '0;
      drn_cnt <= '0;
    end else begin
      if (state == S_IDLE && start) row_cnt <= '0;
      else if (fifo_rinc)           row_cnt <= row_cnt + RW'(1);
      if (state == S_STREAM && state_nx == S_DRN) drn_cnt <= '0;
      else if (state == S_DRN)                    drn_cnt <= drn_cnt + DCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sa_en <= 1'b0;
    else     sa_en <= adv;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DW-1:0] d;
    logic [DW-1:0] out_q;

    assign d = inject[k*DW +: DW];

    if (k == 0) begin : g_direct
      always_ff @(posedge clk) begin
        if (rst)      out_q <= '0;
        else if (adv) out_q <= d;
      end
    end else begin : g_chain
      logic [DW-1:0] chain [k];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < k; j++) chain[j] <= '0;
          out_q <= '0;
        end else if (adv) begin
          chain[0] <= d;
          for (int j = 1; j < k; j++) chain[j] <= chain[j-1];
          out_q <= chain[k-1];
        end
      end
    end

    assign sa_in[k*DW +: DW] = out_q;
  end

endmodule

// File: tb/tb_sa_row_feeder.sv
// tb_sa_row_feeder: directed jobs against a queue-level model of the
// row feeder, plus literal per-cycle expectations for key scenarios.
module tb_sa_row_feeder;

  localparam int LANES = 3;
  localparam int DW    = 8;
  localparam int ROWS  = 3;
  localparam int DRAIN = 4;
  localparam int W     = LANES * DW;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] fifo_rdata;
  logic         fifo_empty;
  logic         fifo_rinc;
  logic         sa_en;
  logic [W-1:0] sa_in;
  logic         busy;
  logic         done;

  sa_row_feeder #(
    .LANES(LANES), .DW(DW), .ROWS(ROWS), .DRAIN(DRAIN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_rinc  (fifo_rinc),
    .sa_en      (sa_en),
    .sa_in      (sa_in),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] fq [$];
  logic         force_empty;
  logic         pop_q = 1'b0;
  logic         chk_en = 1'b0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           gcyc = 0;

  logic [W-1:0] lg_in   [0:4095];
  bit           lg_en   [0:4095];
  bit           lg_done [0:4095];
  bit           lg_rinc [0:4095];
  bit           lg_busy [0:4095];

  // model: job phase 0 idle, 1 stream, 2 drain, 3 done
  int           m_phase = 0;
  int           m_pops = 0;
  int           m_drn = 0;
  logic         m_en = 1'b0;
  logic [W-1:0] m_hist [$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // lane k shows lane k of the row injected k advances before the newest
  function automatic logic [W-1:0] m_sa_in();
    logic [W-1:0] r;
    logic [W-1:0] row;
    int           m;
    r = '0;
    m = m_hist.size();
    for (int k = 0; k < LANES; k++) begin
      if (m > k) begin
        row = m_hist[m-1-k];
        r[k*DW +: DW] = row[k*DW +: DW];
      end
    end
    return r;
  endfunction

  always @(negedge clk) begin : cmp
    logic         e_rinc;
    logic         e_adv;
    logic [W-1:0] row;
    if (gcyc < 4096) begin
      lg_in[gcyc]   = sa_in;
      lg_en[gcyc]   = sa_en;
      lg_done[gcyc] = done;
      lg_rinc[gcyc] = fifo_rinc;
      lg_busy[gcyc] = busy;
    end
    if (chk_en) begin
      e_rinc = !rst && m_phase == 1 && !fifo_empty && m_pops < ROWS;
      check("m_rinc", 32'(fifo_rinc), 32'(e_rinc));
      check("m_busy", 32'(busy), 32'(m_phase != 0));
      check("m_done", 32'(done), 32'(m_phase == 3));
      check("m_sa_en", 32'(sa_en), 32'(m_en));
      check("m_sa_in", 32'(sa_in), 32'(m_sa_in()));
    end
    pop_q = fifo_rinc;
    if (rst) begin
      m_phase = 0;
      m_pops  = 0;
      m_drn   = 0;
      m_en    = 1'b0;
      m_hist.delete();
    end else begin
      e_adv = (m_phase == 1 && !fifo_empty && m_pops < ROWS) || m_phase == 2;
      row   = (m_phase == 1) ? fifo_rdata : '0;
      if (e_adv) begin
        m_hist.push_back(row);
        if (m_hist.size() > LANES) void'(m_hist.pop_front());
      end
      m_en = e_adv;
      case (m_phase)
        0: if (start) begin m_phase = 1; m_pops = 0; end
        1: if (e_adv) begin
             m_pops++;
             if (m_pops == ROWS) begin m_phase = 2; m_drn = 0; end
           end
        2: begin m_drn++; if (m_drn == DRAIN) m_phase = 3; end
        default: m_phase = 0;
      endcase
    end
    gcyc++;
  end

  task automatic refresh();
    fifo_empty = force_empty || fq.size() == 0;
    fifo_rdata = (fq.size() > 0) ? fq[0] : '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (pop_q && fq.size() > 0) void'(fq.pop_front());
    start = 1'b0;
    refresh();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic set_force(input logic v);
    force_empty = v;
    refresh();
  endtask

  task automatic push3();
    fq.push_back(24'h030201);
    fq.push_back(24'h060504);
    fq.push_back(24'h090807);
    refresh();
  endtask

  task automatic start_job(output int t0);
    tick();
    start = 1'b1;
    t0 = gcyc;
  endtask

  task automatic wait_done(input int t0, input int lim, output int dc);
    dc = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (done === 1'b1) begin
        dc = gcyc - t0;
        break;
      end
    end
    if (dc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", lim);
    end
  endtask

  logic [W-1:0] texp [0:9];

  initial begin
    int t0;
    int t1;
    int dc;
    int nd;
    logic [W-1:0] e;
    texp = '{24'h0, 24'h0, 24'h000001, 24'h000204, 24'h030507,
             24'h060800, 24'h090000, 24'h0, 24'h0, 24'h0};
    rst = 1'b1;
    start = 1'b0;
    force_empty = 1'b0;
    refresh();
    run(2);
    chk_en = 1'b1;
    run(1);
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sa_en", 32'(sa_en), 32'(0));
    check("rst_sa_in", 32'(sa_in), 32'(0));
    check("rst_rinc", 32'(fifo_rinc), 32'(0));
    rst = 1'b0;
    run(2);

    // default job
    push3();
    start_job(t0);
    wait_done(t0, 30, dc);
    check("t1_done_cyc", 32'(dc), 32'(8));
    run(3);
    for (int n = 0; n < 10; n++) begin
      check("t1_rinc", 32'(lg_rinc[t0+n]), 32'(n >= 1 && n <= 3));
      check("t1_sa_en", 32'(lg_en[t0+n]), 32'(n >= 2 && n <= 8));
      check("t1_sa_in", 32'(lg_in[t0+n]), 32'(texp[n]));
      check("t1_done", 32'(lg_done[t0+n]), 32'(n == 8));
      check("t1_busy", 32'(lg_busy[t0+n]), 32'(n >= 1 && n <= 8));
    end

    // stall for cycles 2-3
    push3();
    start_job(t0);
    tick();
    tick();
    set_force(1'b1);
    tick();
    tick();
    set_force(1'b0);
    wait_done(t0, 30, dc);
    check("t2_done_cyc", 32'(dc), 32'(10));
    run(3);
    for (int n = 0; n < 12; n++) begin
      if (n <= 2)      e = texp[n];
      else if (n <= 4) e = texp[2];
      else             e = texp[n-2];
      check("t2_sa_in", 32'(lg_in[t0+n]), 32'(e));
      check("t2_rinc", 32'(lg_rinc[t0+n]), 32'(n == 1 || n == 4 || n == 5));
      check("t2_sa_en", 32'(lg_en[t0+n]),
            32'(n >= 2 && n <= 10 && n != 3 && n != 4));
    end

    // start with empty FIFO
    start_job(t0);
    run(20);
    check("t3_busy", 32'(lg_busy[t0+19]), 32'(1));
    check("t3_rinc", 32'(lg_rinc[t0+19]), 32'(0));
    check("t3_sa_en", 32'(lg_en[t0+19]), 32'(0));
    push3();
    wait_done(t0, 40, dc);
    check("t3_done_cyc", 32'(dc), 32'(27));
    run(3);

    // reset mid-job at cycle 4
    push3();
    start_job(t0);
    run(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    run(15);
    check("t4_sa_in", 32'(lg_in[t0+5]), 32'(0));
    check("t4_sa_en", 32'(lg_en[t0+5]), 32'(0));
    check("t4_busy", 32'(lg_busy[t0+5]), 32'(0));
    nd = 0;
    for (int n = 4; n < 19; n++) nd += int'(lg_done[t0+n]);
    check("t4_no_done", 32'(nd), 32'(0));
    push3();
    start_job(t0);
    wait_done(t0, 30, dc);
    check("t4_done_cyc", 32'(dc), 32'(8));
    run(2);
    check("t4_clean_c3", 32'(lg_in[t0+3]), 32'(24'h000204));
    check("t4_clean_c4", 32'(lg_in[t0+4]), 32'(24'h030507));

    // stray starts at 3 and 8, back-to-back start at 9
    fq.push_back(24'h0c0b0a);
    fq.push_back(24'h0f0e0d);
    fq.push_back(24'h121110);
    push3();
    start_job(t0);
    run(3);
    start = 1'b1;
    run(5);
    check("t5_done8", 32'(done), 32'(1));
    start = 1'b1;
    tick();
    check("t5_idle9", 32'(busy), 32'(0));
    start = 1'b1;
    t1 = gcyc;
    tick();
    check("t5_rinc10", 32'(fifo_rinc), 32'(1));
    check("t5_busy10", 32'(busy), 32'(1));
    check("t5_fq_left", 32'(fq.size()), 32'(3));
    wait_done(t1, 30, dc);
    check("t5_done2_cyc", 32'(dc), 32'(8));
    run(3);
    check("t5_lane_c4", 32'(lg_in[t1+4]), 32'(24'h030507));

    // five rows queued, three consumed
    fq.push_back(24'h151413);
    fq.push_back(24'h181716);
    push3();
    start_job(t0);
    wait_done(t0, 30, dc);
    check("t6_done_cyc", 32'(dc), 32'(8));
    run(2);
    check("t6_fq_left", 32'(fq.size()), 32'(2));
    check("t6_not_empty", 32'(fifo_empty), 32'(0));
    check("t6_lane_c2", 32'(lg_in[t0+2]), 32'(24'h000013));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
